debounce_multi: RTL

Multi-channel successor to the single-button debouncer. It synchronises NUM_CH asynchronous button inputs and filters bounce on each channel independently. For each channel it produces a debounced level, one-cycle rise/fall pulses, a long-press pulse, a held level and an optional auto-repeat pulse train. It sits between the board pins and the stopwatch control FSM, replacing per-button debounce instances.

---
 rtl/debounce_pkg.sv | 29 ++
 rtl/debounce_channel.sv | 169 ++++++++++++++++
 rtl/debounce_multi.sv | 69 ++++++
 3 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debounce_pkg : shared types and helpers for the multi-channel debouncer  |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_CHK_HIGH = 2'd1,
    S_HIGH     = 2'd2,
    S_CHK_LOW  = 2'd3
  } ch_state_t;

  function automatic logic [31:0] ms_to_cycles(input longint unsigned freq,
                                               input longint unsigned ms);
    longint unsigned cyc;
    cyc = (freq / 64'd1000) * ms;
    return cyc[31:0];
  endfunction

  // Width able to hold 0..max_count, never narrower than one bit.
  function automatic int cnt_width(input longint unsigned max_count);
    if (max_count == 64'd0) return 1;
    return $clog2(max_count + 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debounce_channel : one button - synchroniser, debounce FSM, long-press   |
// |                    detection and auto-repeat pulse generation            |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYC  = 1000,
  parameter int unsigned LONG_CYC    = 5000,
  parameter int unsigned REPEAT_CYC  = 2000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  output logic result,
  output logic rise,
  output logic fall,
  output logic long_press,
  output logic held,
  output logic rpt
);

  localparam int CNT_W  = cnt_width(64'(STABLE_CYC) - 64'd1);
  localparam int LCNT_W = cnt_width(64'(LONG_CYC) - 64'd1);
  localparam int RCNT_W = cnt_width((REPEAT_CYC == 0) ? 64'd0 : 64'(REPEAT_CYC) - 64'd1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYC - 1);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_CYC - 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'((REPEAT_CYC == 0) ? 0 : REPEAT_CYC - 1);
  localparam logic              RPT_EN    = (REPEAT_CYC != 0);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  ch_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LCNT_W-1:0]      lcnt_q, lcnt_d;
  logic [RCNT_W-1:0]      rcnt_q, rcnt_d;
  logic                   result_q, result_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   long_press_q, long_press_d;
  logic                   held_q, held_d;
  logic                   rpt_q, rpt_d;
  logic                   sync_lvl;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], button};
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= '0;
      state_q      <= S_LOW;
      cnt_q        <= '0;
      lcnt_q       <= '0;
      rcnt_q       <= '0;
      result_q     <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      long_press_q <= 1'b0;
      held_q       <= 1'b0;
      rpt_q        <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lcnt_q       <= lcnt_d;
      rcnt_q       <= rcnt_d;
      result_q     <= result_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      long_press_q <= long_press_d;
      held_q       <= held_d;
      rpt_q        <= rpt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lcnt_d       = lcnt_q;
    rcnt_d       = rcnt_q;
    result_d     = result_q;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    long_press_d = 1'b0;
    held_d       = held_q;
    rpt_d        = 1'b0;

    // Repeat timer only runs once the long press has been recognised.
    if (RPT_EN && held_q) begin
      if (rcnt_q == RCNT_LAST) begin
        rpt_d  = 1'b1;
        rcnt_d = '0;
      end else begin
        rcnt_d = rcnt_q + RCNT_W'(1);
      end
    end

    if (state_q == S_HIGH || state_q == S_CHK_LOW) begin
      if (!held_q && lcnt_q == LCNT_LAST) begin
        long_press_d = 1'b1;
        held_d       = 1'b1;
      end
      if (lcnt_q != LCNT_LAST) begin
        lcnt_d = lcnt_q + LCNT_W'(1);
      end
    end

    case (state_q)
      S_LOW: begin
        if (sync_lvl) begin
          state_d = S_CHK_HIGH;
          cnt_d   = '0;
        end
      end
      S_CHK_HIGH: begin
        if (!sync_lvl) begin
          state_d = S_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = S_HIGH;
          result_d = 1'b1;
          rise_d   = 1'b1;
          lcnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!sync_lvl) begin
          state_d = S_CHK_LOW;
          cnt_d   = '0;
        end
      end
      S_CHK_LOW: begin
        if (sync_lvl) begin
          state_d = S_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          // Release wins over any long-press/repeat event on the same edge.
          state_d      = S_LOW;
          result_d     = 1'b0;
          fall_d       = 1'b1;
          held_d       = 1'b0;
          lcnt_d       = '0;
          rcnt_d       = '0;
          rpt_d        = 1'b0;
          long_press_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_LOW;
      end
    endcase
  end

  assign result     = result_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign long_press = long_press_q;
  assign held       = held_q;
  assign rpt        = rpt_q;

endmodule
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debounce_multi : NUM_CH independent button debouncers with long-press    |
// |                  and auto-repeat outputs                                 |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned STABLE_MS   = 10,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 200,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] button,
  output logic [NUM_CH-1:0] result,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] long_press,
  output logic [NUM_CH-1:0] held,
  output logic [NUM_CH-1:0] rpt
);

  localparam int unsigned STABLE_CYC = ms_to_cycles(64'(CLK_FREQ_HZ), 64'(STABLE_MS));
  localparam int unsigned LONG_CYC   = ms_to_cycles(64'(CLK_FREQ_HZ), 64'(LONG_MS));
  localparam int unsigned REPEAT_CYC = (REPEAT_MS == 0) ? 0 :
                                       ms_to_cycles(64'(CLK_FREQ_HZ), 64'(REPEAT_MS));

  if (STABLE_CYC < 1) begin : g_chk_stable
    $error("debounce_multi: STABLE_CYC must be at least 1");
  end
  if (LONG_CYC < 1) begin : g_chk_long
    $error("debounce_multi: LONG_CYC must be at least 1");
  end
  if (REPEAT_MS != 0 && REPEAT_CYC < 1) begin : g_chk_repeat
    $error("debounce_multi: REPEAT_MS too small for CLK_FREQ_HZ");
  end
  if (NUM_CH < 1) begin : g_chk_num_ch
    $error("debounce_multi: NUM_CH must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("debounce_multi: SYNC_STAGES must be at least 2");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYC (STABLE_CYC),
      .LONG_CYC   (LONG_CYC),
      .REPEAT_CYC (REPEAT_CYC),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_channel (
      .clk       (clk),
      .reset_n   (reset_n),
      .button    (button[i]),
      .result    (result[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .long_press(long_press[i]),
      .held      (held[i]),
      .rpt       (rpt[i])
    );
  end

endmodule
`default_nettype wire
